// File: rtl/alu_pkg.sv
// Shared definitions for the vector ALU issue path: R_ins/opcode/width codes,
// op classes and issue-controller state encodings.
package alu_pkg;

  localparam logic [5:0] VNOP   = 6'd0;
  localparam logic [5:0] VAND   = 6'd1;
  localparam logic [5:0] VOR    = 6'd2;
  localparam logic [5:0] VXOR   = 6'd3;
  localparam logic [5:0] VNOT   = 6'd4;
  localparam logic [5:0] VMOV   = 6'd5;
  localparam logic [5:0] VADD   = 6'd6;
  localparam logic [5:0] VSUB   = 6'd7;
  localparam logic [5:0] VMULEU = 6'd8;
  localparam logic [5:0] VMULOU = 6'd9;
  localparam logic [5:0] VSLL   = 6'd10;
  localparam logic [5:0] VSRL   = 6'd11;
  localparam logic [5:0] VSRA   = 6'd12;
  localparam logic [5:0] VRTTH  = 6'd13;
  localparam logic [5:0] VDIV   = 6'd14;
  localparam logic [5:0] VMOD   = 6'd15;
  localparam logic [5:0] VSQEU  = 6'd16;
  localparam logic [5:0] VSQOU  = 6'd17;
  localparam logic [5:0] VSQRT  = 6'd18;

  localparam logic [5:0] R_ALU     = 6'b101010;
  localparam logic [5:0] LOAD      = 6'b100000;
  localparam logic [5:0] STORE     = 6'b100001;
  localparam logic [5:0] BRANCH_EZ = 6'b100010;
  localparam logic [5:0] BRANCH_NZ = 6'b100011;
  localparam logic [5:0] NOP       = 6'b111100;

  localparam logic [1:0] Width_8  = 2'b00;
  localparam logic [1:0] Width_16 = 2'b01;
  localparam logic [1:0] Width_32 = 2'b10;
  localparam logic [1:0] Width_64 = 2'b11;

  typedef enum logic [1:0] {
    CLS_DROP   = 2'd0,
    CLS_SINGLE = 2'd1,
    CLS_MULTI  = 2'd2
  } op_class_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    MC_GO   = 3'd2,
    MC_WAIT = 3'd3,
    HOLD    = 3'd4
  } state_t;

  function automatic logic is_div_op(input logic [5:0] rins);
    return (rins == VDIV) || (rins == VMOD);
  endfunction

endpackage

// File: rtl/alu_op_classify.sv
// Combinational op classifier: decides whether an instruction runs on the
// single-cycle ALU, the shared multi-cycle unit, or produces no result.
module alu_op_classify
  import alu_pkg::*;
(
  input  logic [0:5] i_op_code,
  input  logic [0:5] i_r_ins,
  output op_class_t  o_class
);

  always_comb begin
    o_class = CLS_DROP;
    if (i_op_code == R_ALU) begin
      case (i_r_ins)
        VAND, VOR, VXOR, VNOT, VMOV, VADD, VSUB,
        VSLL, VSRL, VSRA, VRTTH:                    o_class = CLS_SINGLE;
        VMULEU, VMULOU, VDIV, VMOD, VSQEU, VSQOU,
        VSQRT:                                      o_class = CLS_MULTI;
        default:                                    o_class = CLS_DROP;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/sequencing controller between ID/EX and the vector ALU datapath.
// Optional divide-by-zero trap enabled by defining ALU_ISSUE_DIV0_TRAP_EN.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:5]        op_code,
  input  logic [0:5]        r_ins,
  input  logic [0:1]        ww,
  input  logic [0:DATA_W-1] ra_val,
  input  logic [0:DATA_W-1] rb_val,
  output logic [0:5]        alu_opcode,
  output logic [0:5]        alu_rins,
  output logic [0:1]        alu_ww,
  output logic [0:DATA_W-1] alu_ra,
  output logic [0:DATA_W-1] alu_rb,
  input  logic [0:DATA_W-1] alu_out,
  output logic              mc_start,
  input  logic              mc_done,
  input  logic [0:DATA_W-1] mc_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [0:DATA_W-1] res_data,
  output logic              res_err,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_trap;
  logic              r_mc_start;
  logic              r_res_valid;
  logic              r_res_err;
  logic [0:DATA_W-1] r_res_data;
  logic [0:5]        r_alu_opcode;
  logic [0:5]        r_alu_rins;
  logic [0:1]        r_alu_ww;
  logic [0:DATA_W-1] r_alu_ra;
  logic [0:DATA_W-1] r_alu_rb;

  op_class_t w_class;
  state_t    w_issue_state;
  logic      w_accept;
  logic      w_div0;

  alu_op_classify u_classify (
    .i_op_code (op_code),
    .i_r_ins   (r_ins),
    .o_class   (w_class)
  );

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  localparam int NB = DATA_W / 8;
  logic [NB-1:0] w_byte_zero;
  logic          w_zero_elem;

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte_zero
    assign w_byte_zero[gi] = ~|rb_val[8*gi +: 8];
  end

  // An element is zero when every byte of its group is zero.
  always_comb begin
    int  eb;
    logic grp;
    grp = 1'b0;
    case (ww)
      Width_8:  eb = 1;
      Width_16: eb = 2;
      Width_32: eb = 4;
      default:  eb = 8;
    endcase
    w_zero_elem = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if ((k % eb) == 0) begin
        grp = 1'b1;
        for (int m = 0; m < 8; m++) begin
          if ((m < eb) && ((k + m) < NB)) grp = grp & w_byte_zero[k+m];
        end
        w_zero_elem = w_zero_elem | grp;
      end
    end
  end

  assign w_div0 = (op_code == R_ALU) && is_div_op(r_ins) && w_zero_elem;
`else
  assign w_div0 = 1'b0;
`endif

  always_comb begin
    case (w_class)
      CLS_SINGLE: w_issue_state = EXEC;
      CLS_MULTI:  w_issue_state = MC_GO;
      default:    w_issue_state = IDLE;
    endcase
  end

  assign in_ready = reset_n && ((r_state == IDLE) || ((r_state == HOLD) && res_ready));
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_trap       <= 1'b0;
      r_mc_start   <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_err    <= 1'b0;
      r_res_data   <= '0;
      r_alu_opcode <= '0;
      r_alu_rins   <= '0;
      r_alu_ww     <= '0;
      r_alu_ra     <= '0;
      r_alu_rb     <= '0;
    end else begin
      // Start pulse is launched at accept so it is high exactly during MC_GO.
      r_mc_start <= w_accept && (w_class == CLS_MULTI) && !w_div0;
      if (w_accept) begin
        r_alu_opcode <= op_code;
        r_alu_rins   <= r_ins;
        r_alu_ww     <= ww;
        r_alu_ra     <= ra_val;
        r_alu_rb     <= rb_val;
        r_trap       <= w_div0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) r_state <= w_issue_state;
        end
        EXEC: begin
          r_res_data  <= alu_out;
          r_res_err   <= 1'b0;
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        MC_GO: begin
          r_cnt <= '0;
          if (r_trap) begin
            r_res_data  <= '1;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_state <= MC_WAIT;
          end
        end
        MC_WAIT: begin
          if (mc_done) begin
            r_res_data  <= mc_result;
            r_res_err   <= 1'b0;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else if (r_cnt == CNT_LAST) begin
            r_res_data  <= '1;
            r_res_err   <= 1'b1;
            r_res_valid <= 1'b1;
            r_state     <= HOLD;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= w_accept ? w_issue_state : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_opcode = r_alu_opcode;
  assign alu_rins   = r_alu_rins;
  assign alu_ww     = r_alu_ww;
  assign alu_ra     = r_alu_ra;
  assign alu_rb     = r_alu_rb;
  assign mc_start   = r_mc_start;
  assign res_valid  = r_res_valid;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: directed ops, expected results queued at
// issue and checked by an independent result monitor.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DATA_W     = 64;
  localparam int MC_TIMEOUT = 64;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  op_code;
  logic [5:0]  r_ins;
  logic [1:0]  ww;
  logic [63:0] ra_val;
  logic [63:0] rb_val;
  logic [5:0]  alu_opcode;
  logic [5:0]  alu_rins;
  logic [1:0]  alu_ww;
  logic [63:0] alu_ra;
  logic [63:0] alu_rb;
  logic [63:0] alu_out;
  logic        mc_start;
  logic        mc_done;
  logic [63:0] mc_result;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic        res_err;
  logic        busy;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_pops = 0;
  int   n_mc_start = 0;
  int   mc_start_cyc = 0;
  int   mc_done_cyc = 0;
  int   mc_delay = 5;
  bit   mc_auto = 1'b1;
  logic [63:0] mc_value = 64'h0;
  exp_t q[$];

  alu_issue_ctrl #(.DATA_W(DATA_W), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(7)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_code    (op_code),
    .r_ins      (r_ins),
    .ww         (ww),
    .ra_val     (ra_val),
    .rb_val     (rb_val),
    .alu_opcode (alu_opcode),
    .alu_rins   (alu_rins),
    .alu_ww     (alu_ww),
    .alu_ra     (alu_ra),
    .alu_rb     (alu_rb),
    .alu_out    (alu_out),
    .mc_start   (mc_start),
    .mc_done    (mc_done),
    .mc_result  (mc_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simple ALU model (64-bit lane): enough for the ops this bench issues.
  always_comb begin
    case (alu_rins)
      VADD:    alu_out = alu_ra + alu_rb;
      VAND:    alu_out = alu_ra & alu_rb;
      default: alu_out = 64'h0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Multi-cycle unit model: answers mc_delay cycles after the start pulse.
  initial begin
    mc_done   = 1'b0;
    mc_result = 64'h0;
    forever begin
      @(negedge clk);
      if (reset_n && mc_start) begin
        n_mc_start++;
        mc_start_cyc = cyc;
        if (mc_auto) begin
          repeat (mc_delay) @(posedge clk);
          #1;
          mc_done     = 1'b1;
          mc_result   = mc_value;
          mc_done_cyc = cyc;
          @(posedge clk);
          #1;
          mc_done = 1'b0;
        end
      end
    end
  end

  // Result monitor: one line per completed transfer, compared against the queue.
  always @(negedge clk) begin
    if (reset_n && res_valid && res_ready) begin
      exp_t e;
      n_pops++;
      $display("txn %0d cyc %0d data=%h err=%b", n_pops, cyc, res_data, res_err);
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result got=%h err=%b exp=none", res_data, res_err);
      end else begin
        e = q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_err", {63'd0, res_err}, {63'd0, e.err});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge with the
  // accept cycle index.
  task automatic send(input logic [5:0] op, input logic [5:0] ri, input logic [1:0] w,
                      input logic [63:0] a, input logic [63:0] b, output int acc_t);
    int k;
    in_valid = 1'b1; op_code = op; r_ins = ri; ww = w; ra_val = a; rb_val = b;
    acc_t = -1;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout got=no_ready exp=ready");
    end
    @(posedge clk);
    #1;
    acc_t = cyc - 1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int f);
    f = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (res_valid) begin
        f = cyc;
        break;
      end
    end
    if (f < 0) begin
      n_checks++; n_errors++;
      $display("FAIL wait_valid_timeout got=0 exp=1");
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) break;
    end
    if (k >= 200) begin
      n_checks++; n_errors++;
      $display("FAIL drain_timeout got=%0d exp=0", q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, t3, f, n0, p0;
    reset_n = 1'b0; in_valid = 1'b0; op_code = '0; r_ins = '0; ww = '0;
    ra_val = '0; rb_val = '0; res_ready = 1'b1;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_res_valid", {63'd0, res_valid}, 64'd0);
    chk("rst_mc_start", {63'd0, mc_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // SINGLE: VADD 1+2, result visible two cycles after the accept cycle
    q.push_back('{64'h3, 1'b0});
    send(R_ALU, VADD, Width_64, 64'h1, 64'h2, t);
    @(negedge clk);
    chk("single_valid_t+1", {63'd0, res_valid}, 64'd0);
    chk("alu_ra_loaded", alu_ra, 64'h1);
    @(negedge clk);
    chk("single_valid_t+2", {63'd0, res_valid}, 64'd1);
    drain();

    // MULTI: VDIV answered 5 cycles after start with 0x7
    mc_auto = 1'b1; mc_delay = 5; mc_value = 64'h7;
    n0 = n_mc_start;
    q.push_back('{64'h7, 1'b0});
    send(R_ALU, VDIV, Width_64, 64'h31, 64'h7, t);
    wait_valid(f);
    n_checks++;
    if (!(f > mc_done_cyc && f <= mc_done_cyc + 2)) begin
      n_errors++;
      $display("FAIL mc_latency got=%0d exp=%0d..%0d", f, mc_done_cyc + 1, mc_done_cyc + 2);
    end
    drain();
    chk("mc_start_pulses", 64'(n_mc_start - n0), 64'd1);

    // mc_done on the timeout cycle is a valid completion
    mc_delay = MC_TIMEOUT; mc_value = 64'h1234;
    q.push_back('{64'h1234, 1'b0});
    send(R_ALU, VMULEU, Width_64, 64'h2, 64'h3, t);
    wait_valid(f);
    chk("mc_edge_latency", 64'(f), 64'(mc_start_cyc + 1 + MC_TIMEOUT));
    drain();

    // Timeout: VSQRT, no mc_done; later stray mc_done is ignored
    mc_auto = 1'b0;
    n0 = n_mc_start;
    q.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    send(R_ALU, VSQRT, Width_64, 64'h10, 64'h0, t);
    wait_valid(f);
    chk("timeout_latency", 64'(f), 64'(mc_start_cyc + 1 + MC_TIMEOUT));
    drain();
    chk("timeout_mc_start_pulses", 64'(n_mc_start - n0), 64'd1);
    p0 = n_pops;
    mc_done = 1'b1; mc_result = 64'h55;
    @(posedge clk);
    #1;
    mc_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("late_done_busy", {63'd0, busy}, 64'd0);
    chk("late_done_no_result", 64'(n_pops - p0), 64'd0);
    @(posedge clk);
    #1;

    // Throughput: three SINGLE ops back to back, one accept per two cycles
    q.push_back('{64'h3, 1'b0});
    send(R_ALU, VADD, Width_64, 64'h1, 64'h2, t);
    q.push_back('{64'h30, 1'b0});
    send(R_ALU, VADD, Width_64, 64'h10, 64'h20, t2);
    q.push_back('{64'h0, 1'b0});
    send(R_ALU, VADD, Width_64, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, t3);
    chk("throughput_gap1", 64'(t2 - t), 64'd2);
    chk("throughput_gap2", 64'(t3 - t2), 64'd2);
    drain();

    // Back-pressure, then release together with a new VAND accept
    res_ready = 1'b0;
    q.push_back('{64'hB, 1'b0});
    send(R_ALU, VADD, Width_64, 64'h5, 64'h6, t);
    wait_valid(f);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_data_stable", res_data, 64'hB);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    p0 = n_pops;
    res_ready = 1'b1;
    q.push_back('{64'h30, 1'b0});
    send(R_ALU, VAND, Width_64, 64'hF0, 64'h3C, t);
    chk("bp_release_pop", 64'(n_pops - p0), 64'd1);
    drain();
    chk("bp_total_pops", 64'(n_pops - p0), 64'd2);

    // DROP: NOP opcode and VNOP produce nothing
    p0 = n_pops;
    send(NOP, VADD, Width_64, 64'h1, 64'h1, t);
    send(R_ALU, VNOP, Width_64, 64'h1, 64'h1, t);
    repeat (3) @(negedge clk);
    chk("drop_busy", {63'd0, busy}, 64'd0);
    chk("drop_no_result", 64'(n_pops - p0), 64'd0);
    @(posedge clk);
    #1;

    // Reset during MC_WAIT
    mc_auto = 1'b0;
    send(R_ALU, VDIV, Width_64, 64'h9, 64'h3, t);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #2;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_res_valid", {63'd0, res_valid}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    n0 = n_mc_start;
    p0 = n_pops;
    repeat (5) @(negedge clk);
    chk("midrst_no_mc_start", 64'(n_mc_start - n0), 64'd0);
    chk("midrst_no_result", 64'(n_pops - p0), 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
